// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, flag positions and sequencer states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110,
    ALU_LSR    = 3'b111
  } alu_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } alu_state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: pass-B, add, subtract, and the bitwise ops; reserved codes yield zero.
module alu_1bit
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       carry_i,
  input  logic [2:0] cntrl_i,
  output logic       result_o,
  output logic       carry_o
);

  logic b_eff;
  logic sum;
  logic cout;

  // Subtraction is A + ~B + carry_in; the sequencer seeds carry_in = 1 for bit 0.
  always_comb begin
    b_eff = (cntrl_i == ALU_SUB) ? ~b_i : b_i;
    sum   = a_i ^ b_eff ^ carry_i;
    cout  = (a_i & b_eff) | (carry_i & (a_i ^ b_eff));
  end

  always_comb begin
    result_o = 1'b0;
    carry_o  = 1'b0;
    case (cntrl_i)
      ALU_PASS_B: result_o = b_i;
      ALU_ADD, ALU_SUB: begin
        result_o = sum;
        carry_o  = cout;
      end
      ALU_AND:    result_o = a_i & b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_XOR:    result_o = a_i ^ b_i;
      default:    result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: runs one WIDTH-bit operation through a single alu_1bit slice,
// LSB first, and presents the assembled result with N/Z/V/C flags.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_cntrl,
  input  logic [5:0]       req_shamt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  alu_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [5:0]       shamt_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_valid_q;

  logic [WIDTH-1:0] lsr_src;
  logic             slice_a;
  logic             slice_b;
  logic [2:0]       slice_op;
  logic             slice_res;
  logic             slice_carry;
  logic [WIDTH-1:0] res_full;
  logic [3:0]       flags_d;

  // LSR runs as pass-B with B taken from A shifted down; bits beyond the MSB read as zero.
  always_comb begin
    lsr_src  = a_q >> shamt_q;
    slice_a  = a_q[cnt_q];
    slice_b  = b_q[cnt_q];
    slice_op = op_q;
    if (op_q == ALU_LSR) begin
      slice_op = ALU_PASS_B;
      slice_b  = lsr_src[cnt_q];
    end
  end

  alu_1bit u_slice (
    .a_i      (slice_a),
    .b_i      (slice_b),
    .carry_i  (carry_q),
    .cntrl_i  (slice_op),
    .result_o (slice_res),
    .carry_o  (slice_carry)
  );

  // On the MSB cycle carry_q is the MSB carry-in and slice_carry the carry-out.
  always_comb begin
    res_full         = result_q;
    res_full[cnt_q]  = slice_res;
    flags_d          = '0;
    flags_d[FLAG_N]  = res_full[WIDTH-1];
    flags_d[FLAG_Z]  = (res_full == '0);
    if (is_arith(op_q)) begin
      flags_d[FLAG_C] = slice_carry;
      flags_d[FLAG_V] = carry_q ^ slice_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      shamt_q      <= '0;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      result_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            a_q      <= req_a;
            b_q      <= req_b;
            op_q     <= req_cntrl;
            shamt_q  <= req_shamt;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= (req_cntrl == ALU_SUB);
            state_q  <= StRun;
          end
        end
        StRun: begin
          result_q <= res_full;
          carry_q  <= slice_carry;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            rsp_result_q <= res_full;
            rsp_flags_q  <= flags_d;
            rsp_valid_q  <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle) && reset_n;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: directed cases, backpressure, mid-run reset, random ops.
`timescale 1ns / 1ps
module tb_alu_serial_seq;

  localparam int W = 64;
  localparam int Limit = 500;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flags;
    int          acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [2:0]    req_cntrl;
  logic [5:0]    req_shamt;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_flags;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb[$];

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cntrl  (req_cntrl),
    .req_shamt  (req_shamt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-word arithmetic; flags {N,Z,V,C}.
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] op, input logic [5:0] sh);
    logic [64:0] s;
    logic [63:0] r;
    logic        v;
    logic        c;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'b011: begin
        r = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      3'b111: r = a >> sh;
      default: r = '0;
    endcase
    return {r, r[63], (r == 64'd0), v, c};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                          input logic [5:0] sh, input int acc);
    logic [67:0] m;
    m = model(a, b, op, sh);
    sb.push_back('{res: m[67:4], flags: m[3:0], acc: acc});
  endtask

  // Called at posedge+#1; returns the accept edge index.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                       input logic [5:0] sh, output int acc);
    int n;
    n = 0;
    req_a = a;
    req_b = b;
    req_cntrl = op;
    req_shamt = sh;
    req_valid = 1'b1;
    while (!req_ready && n < Limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    push_exp(a, b, op, sh, acc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Scramble inputs while RUN to show they are ignored.
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_cntrl = 3'($urandom);
    req_shamt = 6'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < Limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || !req_ready) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: latency on rsp_valid rise, stability while held, compare on handshake.
  logic        prev_valid = 1'b0;
  logic [63:0] held_res;
  logic [3:0]  held_flags;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (rsp_valid && req_ready) check("ready_and_valid", 64'd1, 64'd0);
        if (rsp_valid && !prev_valid) begin
          held_res = rsp_result;
          held_flags = rsp_flags;
          if (sb.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
          else check("latency", 64'(cyc - sb[0].acc), 64'(W));
        end else if (rsp_valid && prev_valid) begin
          check("hold_result", rsp_result, held_res);
          check("hold_flags", 64'(rsp_flags), 64'(held_flags));
        end
        if (rsp_valid && rsp_ready && sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("result", rsp_result, e.res);
          check("flags", 64'(rsp_flags), 64'(e.flags));
        end
        prev_valid = rsp_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    int acc;
    int n;
    logic [63:0] ra;
    logic [63:0] rb;
    reset_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_cntrl = '0;
    req_shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_result", rsp_result, 64'd0);
    check("rst_flags", 64'(rsp_flags), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", 64'(req_ready), 64'd1);

    issue(64'd5, 64'd3, 3'b010, 6'd0, acc);
    issue(64'd5, 64'd5, 3'b011, 6'd0, acc);
    issue(64'd3, 64'd5, 3'b011, 6'd0, acc);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 6'd0, acc);
    issue(64'hF0, 64'h1234, 3'b111, 6'd4, acc);
    issue(64'h8000_0000_0000_0000, 64'd0, 3'b111, 6'd63, acc);
    issue(64'hDEAD_BEEF, 64'h1234_5678, 3'b001, 6'd0, acc);
    drain();

    // Backpressure: response held 10 cycles while a new request waits.
    rsp_ready = 1'b0;
    issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 3'b010, 6'd0, acc);
    n = 0;
    while (!rsp_valid && n < Limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    ra = 64'hAAAA_5555_0000_FFFF;
    rb = 64'h0F0F_F0F0_3C3C_C3C3;
    req_a = ra;
    req_b = rb;
    req_cntrl = 3'b110;
    req_shamt = 6'd0;
    req_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after", 64'(req_ready), 64'd1);
    check("bp_valid_after", 64'(rsp_valid), 64'd0);
    push_exp(ra, rb, 3'b110, 6'd0, cyc + 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_accepted", 64'(req_ready), 64'd0);
    drain();

    // Reset during bit 20 of an ADD: discarded, outputs cleared.
    issue(64'hFFFF_0000_1234_5678, 64'h0000_FFFF_8765_4321, 3'b010, 6'd0, acc);
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mrst_result", rsp_result, 64'd0);
    check("mrst_flags", 64'(rsp_flags), 64'd0);
    check("mrst_req_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_idle", 64'(req_ready), 64'd1);
    issue(64'hFF, 64'h0F, 3'b100, 6'd0, acc);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = {$urandom, $urandom};
        1: ra = '0;
        2: ra = '1;
        default: ra = 64'd1 << $urandom_range(0, 63);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      issue(ra, rb, op, 6'($urandom), acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
